// File: rtl/wload_pkg.sv
// Shared definitions for the weight loader: word/byte geometry, default
// load length, FSM state encoding and a sign-extension helper used by the
// optional checksum (WLOAD_CHECKSUM_EN).
package wload_pkg;

    localparam int WLOAD_N_GROUPS = 200;
    localparam int WLOAD_WORD_W   = 64;
    localparam int WLOAD_BYTE_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } wload_state_t;

    // Sign-extend one int8 weight to the 16-bit checksum width.
    function automatic logic [15:0] sext16(input logic [WLOAD_BYTE_W-1:0] b);
        return {{(16 - WLOAD_BYTE_W){b[WLOAD_BYTE_W-1]}}, b};
    endfunction

endpackage

// File: rtl/weight_loader_if.sv
// Bus-side valid/ready word stream into the weight loader.
// master drives words (DMA/bus side), slave accepts them (weight_loader).
interface weight_loader_if;
    import wload_pkg::*;

    logic [WLOAD_WORD_W-1:0] s_data;
    logic                    s_valid;
    logic                    s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/wload_fifo2.sv
// Two-entry first-word-fall-through FIFO for 64-bit weight words.
// The head word is visible on o_data whenever o_empty is low. A push on a
// full FIFO is taken only together with a pop, so occupancy stays at two.
// i_clear empties the FIFO synchronously and wins over push/pop.
module wload_fifo2
    import wload_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clear,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [WLOAD_WORD_W-1:0] i_data,
    output logic [WLOAD_WORD_W-1:0] o_data,
    output logic                    o_full,
    output logic                    o_empty
);

    logic [WLOAD_WORD_W-1:0] r_mem [2];
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_data    = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping.
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_clear) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_ok) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop_ok)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Word storage.
    // NOTE: data storage has no reset; r_count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_clear) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/weight_loader.sv
// Weight loader top: accepts N_GROUPS/2 64-bit words per load over a
// valid/ready stream, buffers them in a two-entry FIFO and unpacks each
// word into two registered 4 x int8 groups, one group per cycle.
// Optional feature macro: WLOAD_CHECKSUM_EN adds a 16-bit running weight
// sum (chk_sum) checked against chk_expected at the end of the load.
// N_GROUPS must be even and at most 255 (grp_cnt is 8 bits wide).
module weight_loader
    import wload_pkg::*;
#(
    parameter int N_GROUPS = WLOAD_N_GROUPS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    weight_loader_if.slave    bus,
    output logic signed [7:0] w1,
    output logic signed [7:0] w2,
    output logic signed [7:0] w3,
    output logic signed [7:0] w4,
    output logic              valid_o,
    output logic              busy,
    output logic              load_done
`ifdef WLOAD_CHECKSUM_EN
    ,
    input  logic [15:0]       chk_expected,
    output logic [15:0]       chk_sum,
    output logic              chk_err
`endif
);

    localparam int N_WORDS = N_GROUPS / 2;
    localparam int WC_W    = $clog2(N_WORDS + 1);
    localparam logic [WC_W-1:0] LP_N_WORDS  = WC_W'(N_WORDS);
    localparam logic [7:0]      LP_LAST_GRP = 8'(N_GROUPS - 1);

    wload_state_t       r_state;
    logic [WC_W-1:0]    r_word_cnt;
    logic [7:0]         r_grp_cnt;
    logic               r_half;
    logic signed [7:0]  r_w1, r_w2, r_w3, r_w4;
    logic               r_valid;
    logic               r_busy;
    logic               r_load_done;

    logic                    w_start_acc;
    logic                    w_accept;
    logic                    w_issue;
    logic                    w_pop;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [WLOAD_WORD_W-1:0] w_head;
    logic [31:0]             w_half_data;

    // start only counts outside LOAD; it also clears the FIFO.
    assign w_start_acc  = start && (r_state != LOAD);
    assign bus.s_ready  = (r_state == LOAD) && !w_fifo_full && (r_word_cnt < LP_N_WORDS);
    assign w_accept     = bus.s_valid && bus.s_ready;
    assign w_issue      = (r_state == LOAD) && !w_fifo_empty;
    assign w_pop        = w_issue && r_half;
    assign w_half_data  = r_half ? w_head[63:32] : w_head[31:0];

    wload_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_start_acc),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_data  (bus.s_data),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Load sequencer: accept counting, group issue and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_word_cnt  <= '0;
            r_grp_cnt   <= 8'd0;
            r_half      <= 1'b0;
            r_w1        <= '0;
            r_w2        <= '0;
            r_w3        <= '0;
            r_w4        <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state     <= LOAD;
                        r_busy      <= 1'b1;
                        r_word_cnt  <= '0;
                        r_grp_cnt   <= 8'd0;
                        r_half      <= 1'b0;
                        r_load_done <= 1'b0;
                    end else if (r_state == DONE) begin
                        // Rises one cycle after the last valid_o.
                        r_load_done <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_accept) r_word_cnt <= r_word_cnt + 1'b1;
                    if (w_issue) begin
                        r_w1      <= w_half_data[7:0];
                        r_w2      <= w_half_data[15:8];
                        r_w3      <= w_half_data[23:16];
                        r_w4      <= w_half_data[31:24];
                        r_valid   <= 1'b1;
                        r_half    <= ~r_half;
                        r_grp_cnt <= r_grp_cnt + 8'd1;
                        if (r_grp_cnt == LP_LAST_GRP) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w1        = r_w1;
    assign w2        = r_w2;
    assign w3        = r_w3;
    assign w4        = r_w4;
    assign valid_o   = r_valid;
    assign busy      = r_busy;
    assign load_done = r_load_done;

`ifdef WLOAD_CHECKSUM_EN
    logic [15:0] r_chk_sum;
    logic        r_chk_err;
    logic [15:0] w_grp_sum;

    assign w_grp_sum = sext16(w_half_data[7:0])   + sext16(w_half_data[15:8]) +
                       sext16(w_half_data[23:16]) + sext16(w_half_data[31:24]);

    // Running sum of issued weights; compared once, on the load_done edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_sum <= 16'd0;
            r_chk_err <= 1'b0;
        end else if (w_start_acc) begin
            r_chk_sum <= 16'd0;
            r_chk_err <= 1'b0;
        end else begin
            if (w_issue) r_chk_sum <= r_chk_sum + w_grp_sum;
            if ((r_state == DONE) && !r_load_done) r_chk_err <= (r_chk_sum != chk_expected);
        end
    end

    assign chk_sum = r_chk_sum;
    assign chk_err = r_chk_err;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: the driver pushes the two expected
// groups of every word it sends; a negedge monitor pops and compares on
// each valid_o cycle and tracks accepts, group counts and load_done timing.
module tb_weight_loader;
    import wload_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    weight_loader_if bus ();

    logic signed [7:0] w1, w2, w3, w4;
    logic              valid_o, busy, load_done;
`ifdef WLOAD_CHECKSUM_EN
    logic [15:0] chk_expected = 16'd0;
    logic [15:0] chk_sum;
    logic        chk_err;
`endif

    weight_loader #(.N_GROUPS(200)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .w1        (w1),
        .w2        (w2),
        .w3        (w3),
        .w4        (w4),
        .valid_o   (valid_o),
        .busy      (busy),
        .load_done (load_done)
`ifdef WLOAD_CHECKSUM_EN
        ,
        .chk_expected (chk_expected),
        .chk_sum      (chk_sum),
        .chk_err      (chk_err)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    int          grp_seen   = 0;
    int          acc_cnt    = 0;
    int          ready_viol = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ld    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard compare, accept/group counting, load_done timing.
    always @(negedge clk) begin
        if (!rst_n) begin
            grp_seen   = 0;
            acc_cnt    = 0;
            ready_viol = 0;
        end else begin
            if (bus.s_ready && acc_cnt >= 100) ready_viol++;
            if (bus.s_valid && bus.s_ready) acc_cnt++;
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_group: got %h, want no group", {w4, w3, w2, w1});
                end else begin
                    check("group", {w4, w3, w2, w1}, exp_q.pop_front());
                end
                grp_seen++;
            end
            if (load_done && !prev_ld) begin
                check("done_after_last_valid", {valid_o, prev_valid}, 2'b01);
                check("done_group_count", grp_seen, 200);
            end
            if (start && !busy) begin
                grp_seen   = 0;
                acc_cnt    = 0;
                ready_viol = 0;
            end
        end
        prev_valid = valid_o;
        prev_ld    = load_done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word, wait (bounded) until it is accepted; returns #1 after the accepting edge.
    task automatic send_word(input logic [63:0] d, input logic push_exp);
        int t;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        if (push_exp) begin
            exp_q.push_back(d[31:0]);
            exp_q.push_back(d[63:32]);
        end
        t = 0;
        @(negedge clk);
        while (!bus.s_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!bus.s_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got s_ready=0 for %0d cycles, want 1", t);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!load_done && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(name, load_done, 1'b1);
    endtask

    function automatic logic [63:0] seq_word(input int i);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(i * 8 + k + 3);
        return w;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        // Reset state
        #12;
        check("rst_s_ready",   bus.s_ready, 1'b0);
        check("rst_valid_o",   valid_o,     1'b0);
        check("rst_busy",      busy,        1'b0);
        check("rst_load_done", load_done,   1'b0);
        check("rst_w",         {w4, w3, w2, w1}, 32'h0);
`ifdef WLOAD_CHECKSUM_EN
        check("rst_chk_sum", chk_sum, 16'h0);
        check("rst_chk_err", chk_err, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_s_ready", bus.s_ready, 1'b0);

        // Load 1: 100 words {8{i}}, s_valid held high, extra word held after the last accept
        start = 1'b1;
        @(negedge clk);
        check("ready_at_start", bus.s_ready, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("ready_n_plus_1", bus.s_ready, 1'b1);
        check("busy_load1",     busy,        1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 100; i++) begin
            b = 8'(i);
            send_word({8{b}}, 1'b1);
        end
        bus.s_data = 64'hDEAD_BEEF_CAFE_F00D;
        wait_done("load1_done");
        bus.s_valid = 1'b0;
        check("load1_accepts",    acc_cnt,      100);
        check("load1_ready_viol", ready_viol,   0);
        check("load1_busy",       busy,         1'b0);
        check("load1_queue",      exp_q.size(), 0);
        tick();

        // Load 2: restart from DONE, latency and byte order, random gaps, mid-load start
        start = 1'b1;
        @(negedge clk);
        check("done_before_restart", load_done, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("done_falls", load_done, 1'b0);
        check("busy_load2", busy,      1'b1);
        @(posedge clk);
        #1;
        send_word(64'h8070_6050_0403_0201, 1'b1);
        bus.s_valid = 1'b0;
        @(negedge clk);
        check("lat_a1_valid", valid_o, 1'b0);
        @(negedge clk);
        check("lat_a2_valid", valid_o, 1'b1);
        check("first_w1", {w1}, 8'h01);
        check("first_w4", {w4}, 8'h04);
        @(negedge clk);
        check("second_w1", {w1}, 8'h50);
        check("second_w4", {w4}, 8'h80);
        @(posedge clk);
        #1;
        for (int i = 1; i < 100; i++) begin
            bus.s_valid = 1'b0;
            while ($urandom_range(0, 9) >= 3) tick();
            send_word(seq_word(i), 1'b1);
            if (i == 30) begin
                bus.s_valid = 1'b0;
                pulse_start();
                check("mid_start_busy", busy,      1'b1);
                check("mid_start_done", load_done, 1'b0);
            end
        end
        bus.s_valid = 1'b0;
        wait_done("load2_done");
        check("load2_accepts", acc_cnt,      100);
        check("load2_queue",   exp_q.size(), 0);
        tick();

        // Load 3: reset asserted after 37 groups
        pulse_start();
        for (int i = 0; i < 19; i++) send_word(seq_word(i + 200), 1'b1);
        bus.s_valid = 1'b0;
        begin
            int t;
            t = 0;
            while (grp_seen < 37 && t < 200) begin
                @(negedge clk);
                #2;
                t++;
            end
        end
        check("groups_before_reset", grp_seen, 37);
        rst_n = 1'b0;
        #1;
        check("async_valid_o", valid_o,     1'b0);
        check("async_s_ready", bus.s_ready, 1'b0);
        check("async_busy",    busy,        1'b0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b1;
        bus.s_data  = 64'h1111_2222_3333_4444;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_after_reset_ready", bus.s_ready, 1'b0);
            check("idle_after_reset_valid", valid_o,     1'b0);
        end
        check("idle_after_reset_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;

        // Load 4: all weights -1
`ifdef WLOAD_CHECKSUM_EN
        chk_expected = 16'hFCE0;
`endif
        pulse_start();
        for (int i = 0; i < 100; i++) send_word({64{1'b1}}, 1'b1);
        bus.s_valid = 1'b0;
        wait_done("load4_done");
        check("load4_queue", exp_q.size(), 0);
`ifdef WLOAD_CHECKSUM_EN
        check("load4_chk_sum", chk_sum, 16'hFCE0);
        check("load4_chk_err", chk_err, 1'b0);
`endif
        tick();

`ifdef WLOAD_CHECKSUM_EN
        // Load 5: same data, wrong expected sum
        chk_expected = 16'h0000;
        pulse_start();
        check("chk_err_cleared", chk_err, 1'b0);
        for (int i = 0; i < 100; i++) send_word({64{1'b1}}, 1'b1);
        bus.s_valid = 1'b0;
        wait_done("load5_done");
        check("load5_chk_err_with_done", chk_err, 1'b1);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
# weight_loader

Front-end for the accelerator's weight path: takes a 64-bit weight stream from the DMA/bus side through a valid/ready handshake and unpacks it into 4×int8 groups, one group per cycle, on the `w1..w4`/`valid_o` interface of the weight distribution stage. It emits exactly `N_GROUPS` groups per load, then raises `load_done`. A two-entry input FIFO decouples the bus from the unpack sequencer.

## Interface
- `N_GROUPS`, default 200: 4-weight groups per load; must be even.
- `N_WORDS`, default `N_GROUPS/2`: 64-bit words per load (derived, not overridable).
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle pulse; begins a load.
- `s_data` input 64: packed weights, eight signed int8 values.
- `s_valid` input 1: `s_data` valid.
- `s_ready` output 1: word accepted when `s_valid && s_ready`.
- `w1`, `w2`, `w3`, `w4` output 8 (signed): current weight group.
- `valid_o` output 1: `w1..w4` valid this cycle.
- `busy` output 1: FSM is in LOAD.
- `load_done` output 1: level; all `N_GROUPS` emitted; cleared by the next `start`.
- `chk_expected` input 16: expected weight sum (`WLOAD_CHECKSUM_EN` only).
- `chk_sum` output 16: running weight sum (`WLOAD_CHECKSUM_EN` only).
- `chk_err` output 1: sum mismatch at end of load (`WLOAD_CHECKSUM_EN` only).

## Operation
- FSM states:
  - IDLE →(`start`)→ LOAD.
  - LOAD →(last group emitted)→ DONE.
  - DONE →(`start`)→ LOAD.
  - `start` is ignored in LOAD.
- On entering LOAD: `word_cnt`, `grp_cnt` and the FIFO are cleared, and `load_done` goes to 0.
- Handshake:
  - `s_ready = (state==LOAD) && !fifo_full && (word_cnt < N_WORDS)`.
  - Words presented after `N_WORDS` have been accepted see `s_ready=0`; they are neither consumed nor dropped.
- Unpack: each FIFO head word yields two groups.
  - Half 0: `w1=[7:0]`, `w2=[15:8]`, `w3=[23:16]`, `w4=[31:24]`.
  - Half 1: `w1=[39:32]`, `w2=[47:40]`, `w3=[55:48]`, `w4=[63:56]`.
  - The head word is popped after half 1 is issued.
- One group is issued per cycle while the FIFO is non-empty. When the FIFO is empty, `valid_o` is 0 and the half pointer holds.
- `grp_cnt` (8 bits) increments per issued group. The issue that brings it to `N_GROUPS` moves the FSM to DONE.
- No downstream backpressure exists: the downstream stage captures every `valid_o` cycle. The block therefore never issues more than `N_GROUPS` groups per load.
- Simultaneous push and pop on a full FIFO is allowed; occupancy stays unchanged.

## Timing
- Reset values: `s_ready=0`, `w1..w4=0`, `valid_o=0`, `busy=0`, `load_done=0`, `chk_sum=0`, `chk_err=0`; state IDLE.
- `w1..w4` and `valid_o` are registered.
- Latency:
  - Cycle N: `start`.
  - N+1: `s_ready=1`.
  - Cycle A: first word accepted.
  - A+1: word enters the FIFO.
  - A+2: first group appears with `valid_o=1`.
  - The following cycle: second group.
- Sustained throughput: 1 word per 2 cycles. With `s_valid` held high, `s_ready` toggles once the FIFO fills.
- `load_done` rises the cycle after the last `valid_o`. At that point `busy=0`.
- `rst_n` low during LOAD aborts immediately: FIFO emptied, outputs return to reset values. A partially delivered group sequence is not resumed.

## Configuration
- `WLOAD_CHECKSUM_EN` defined:
  - `chk_sum` is a 16-bit wrap-around sum of all sign-extended weights issued, cleared on `start`.
  - `chk_err` is set together with `load_done` when `chk_sum != chk_expected`, and cleared on `start`.
- `WLOAD_CHECKSUM_EN` undefined: the three `chk_*` ports and the adder tree are absent.

## Structure
- Shared package `wload_pkg`:
  - Constants `WLOAD_N_GROUPS`, `WLOAD_WORD_W=64`, `WLOAD_BYTE_W=8`.
  - State enum IDLE/LOAD/DONE.
- Sub-module `wload_fifo2`: 2-entry, 64-bit, first-word-fall-through FIFO with `push`, `pop`, `full`, `empty`, and synchronous clear on `start`.

## Test plan
- Reset, then `start`; feed 100 words `{8{i[7:0]}}` with `s_valid` held high. Required: 200 `valid_o` cycles, then `load_done=1`; `s_ready` never high after the 100th accept.
- Word `0x8070605004030201`. Required: first group `w1..w4 = 01,02,03,04`; next cycle `50,60,70,80` (`w4 = -128`).
- Random `s_valid` gaps (30% duty). Required: no duplicated or missing group; `valid_o` deasserted during starvation; order preserved.
- `start` pulsed mid-LOAD. Required: ignored. Second `start` in DONE: counters restart; `load_done` falls the next cycle.
- `rst_n` asserted after 37 groups. Required: `valid_o=0` and `s_ready=0` asynchronously; state IDLE after release.
- With `WLOAD_CHECKSUM_EN`, all weights = -1 and `chk_expected=0xFCE0`. Required: `chk_err=0`. With `chk_expected=0x0000`: `chk_err=1` with `load_done`.
